// File: rtl/sys_clock_gen_pkg.sv
// Shared types and sizing helpers for the divided-clock generator.
package sys_clock_gen_pkg;

    typedef enum logic {
        ST_OFFSET = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // Wide enough to hold both the offset compare value and halfcycle-1.
    function automatic int cnt_width(input int halfcycle, input int offset);
        int m;
        int w;
        m = (halfcycle > offset + 1) ? halfcycle : offset + 1;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sys_clock_gen_if.sv
// Enable/output bundle of one clock generator; strobes exist only with SYS_CLOCK_GEN_STROBE_EN.
interface sys_clock_gen_if;

    logic en;
    logic sys_clk;
    logic running;
`ifdef SYS_CLOCK_GEN_STROBE_EN
    logic rise_stb;
    logic fall_stb;

    modport master (output en, input sys_clk, input running, input rise_stb, input fall_stb);
    modport slave  (input en, output sys_clk, output running, output rise_stb, output fall_stb);
`else
    modport master (output en, input sys_clk, input running);
    modport slave  (input en, output sys_clk, output running);
`endif

endinterface

// File: rtl/sys_clock_gen_cnt.sv
// Up-counter with enable, synchronous clear and terminal-compare flag.
// Latency: o_tc is combinational from the count; backpressure: i_en=0 holds the count.
module sys_clock_gen_cnt #(
    parameter int CW = 4
) (
    input  logic          i_sysclk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic [CW-1:0] i_term,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= i_clr ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/sys_clock_gen.sv
// Divided clock from sysclk with programmable half-period/start offset; strobes under SYS_CLOCK_GEN_STROBE_EN.
// Latency: outputs update on the compare edge itself; backpressure: en=0 freezes state and zeroes strobes.
module sys_clock_gen
    import sys_clock_gen_pkg::*;
#(
    parameter int halfcycle = 5000,
    parameter int offset    = 1234
) (
    input  logic            sysclk,
    input  logic            rst_n,
    sys_clock_gen_if.slave  bus
);

    localparam int            CW      = cnt_width(halfcycle, offset);
    localparam logic [CW-1:0] OFF_TC  = CW'(offset);
    localparam logic [CW-1:0] HALF_TC = CW'(halfcycle - 1);

    if (halfcycle < 1 || offset < 0) begin : g_param_err
        $fatal(1, "sys_clock_gen: halfcycle must be >= 1 and offset >= 0");
    end

    state_t        r_state;
    state_t        w_nxt_state;
    logic          r_sys_clk;
    logic          w_nxt_clk;
    logic          r_running;
    logic          w_nxt_run;
    logic [CW-1:0] w_term;
    logic [CW-1:0] w_cnt;
    logic          w_tc;

    assign w_term = (r_state == ST_OFFSET) ? OFF_TC : HALF_TC;

    // Counter clears on every terminal compare, so it never wraps.
    sys_clock_gen_cnt #(
        .CW (CW)
    ) u_cnt (
        .i_sysclk (sysclk),
        .i_rst_n  (rst_n),
        .i_en     (bus.en),
        .i_clr    (w_tc),
        .i_term   (w_term),
        .o_cnt    (w_cnt),
        .o_tc     (w_tc)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_OFFSET;
            r_sys_clk <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_sys_clk <= w_nxt_clk;
            r_running <= w_nxt_run;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_clk   = r_sys_clk;
        w_nxt_run   = r_running;
        if (bus.en && w_tc) begin
            case (r_state)
                ST_OFFSET: begin
                    w_nxt_state = ST_RUN;
                    w_nxt_clk   = 1'b1;
                    w_nxt_run   = 1'b1;
                end
                ST_RUN: begin
                    w_nxt_clk = ~r_sys_clk;
                end
                default: begin
                    w_nxt_state = ST_OFFSET;
                end
            endcase
        end
    end

    assign bus.sys_clk = r_sys_clk;
    assign bus.running = r_running;

`ifdef SYS_CLOCK_GEN_STROBE_EN
    logic r_rise_stb;
    logic r_fall_stb;
    logic w_rise;
    logic w_fall;

    // A held clock never changes, so en=0 yields no strobes.
    assign w_rise = w_nxt_clk & ~r_sys_clk;
    assign w_fall = ~w_nxt_clk & r_sys_clk;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise_stb <= 1'b0;
            r_fall_stb <= 1'b0;
        end else begin
            r_rise_stb <= w_rise;
            r_fall_stb <= w_fall;
        end
    end

    assign bus.rise_stb = r_rise_stb;
    assign bus.fall_stb = r_fall_stb;
`endif

endmodule

// File: tb/tb_sys_clock_gen.sv
// Bench for sys_clock_gen: six instances on one sysclk checked against an enabled-tick arithmetic model.
module tb_sys_clock_gen;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b1;
    logic [5:0] tb_en  = '0;

    int hc  [6] = '{3, 1, 4, 2, 5000, 5000};
    int off [6] = '{2, 0, 1, 3, 1234, 3718};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sysclk = ~sysclk;

    sys_clock_gen_if if0 ();
    sys_clock_gen_if if1 ();
    sys_clock_gen_if if2 ();
    sys_clock_gen_if if3 ();
    sys_clock_gen_if if4 ();
    sys_clock_gen_if if5 ();

    assign if0.en = tb_en[0];
    assign if1.en = tb_en[1];
    assign if2.en = tb_en[2];
    assign if3.en = tb_en[3];
    assign if4.en = tb_en[4];
    assign if5.en = tb_en[5];

    wire [5:0] o_clk = {if5.sys_clk, if4.sys_clk, if3.sys_clk, if2.sys_clk, if1.sys_clk, if0.sys_clk};
    wire [5:0] o_run = {if5.running, if4.running, if3.running, if2.running, if1.running, if0.running};
`ifdef SYS_CLOCK_GEN_STROBE_EN
    wire [5:0] o_rise = {if5.rise_stb, if4.rise_stb, if3.rise_stb, if2.rise_stb, if1.rise_stb, if0.rise_stb};
    wire [5:0] o_fall = {if5.fall_stb, if4.fall_stb, if3.fall_stb, if2.fall_stb, if1.fall_stb, if0.fall_stb};
`endif

    sys_clock_gen #(.halfcycle(3),    .offset(2))    u0 (.sysclk(sysclk), .rst_n(rst_n), .bus(if0));
    sys_clock_gen #(.halfcycle(1),    .offset(0))    u1 (.sysclk(sysclk), .rst_n(rst_n), .bus(if1));
    sys_clock_gen #(.halfcycle(4),    .offset(1))    u2 (.sysclk(sysclk), .rst_n(rst_n), .bus(if2));
    sys_clock_gen #(.halfcycle(2),    .offset(3))    u3 (.sysclk(sysclk), .rst_n(rst_n), .bus(if3));
    sys_clock_gen #(.halfcycle(5000), .offset(1234)) u4 (.sysclk(sysclk), .rst_n(rst_n), .bus(if4));
    sys_clock_gen #(.halfcycle(5000), .offset(3718)) u5 (.sysclk(sysclk), .rst_n(rst_n), .bus(if5));

    // Model state: number of enabled edges since reset release, and whether the last edge was enabled.
    int         m_n [6];
    logic [5:0] m_last_en = '0;

    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) m_n[i] = 0;
            m_last_en = '0;
        end else begin
            m_last_en = tb_en;
            for (int i = 0; i < 6; i++) if (tb_en[i]) m_n[i] = m_n[i] + 1;
        end
    end

    // After n enabled edges: low until edge offset+1, then high for halfcycle edges, low for halfcycle, ...
    function automatic logic mclk(input int i, input int n);
        if (n < off[i] + 1) return 1'b0;
        return (((n - off[i] - 1) / hc[i]) % 2) == 0;
    endfunction

    function automatic logic mrun(input int i, input int n);
        return n >= off[i] + 1;
    endfunction

`ifdef SYS_CLOCK_GEN_STROBE_EN
    function automatic logic mrise(input int i);
        return m_last_en[i] && mclk(i, m_n[i]) && !mclk(i, m_n[i] - 1);
    endfunction

    function automatic logic mfall(input int i);
        return m_last_en[i] && !mclk(i, m_n[i]) && mclk(i, m_n[i] - 1);
    endfunction
`endif

    task automatic reset_all();
        tb_en = '0;
        @(negedge sysclk);
        rst_n = 1'b0;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        tb_en = 6'($urandom);
        repeat (2) @(negedge sysclk);
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (o_clk[i] !== 1'b0 || o_run[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset inst%0d: clk=%b run=%b, required 0/0", i, o_clk[i], o_run[i]);
            end
`ifdef SYS_CLOCK_GEN_STROBE_EN
            n_tests++;
            if (o_rise[i] !== 1'b0 || o_fall[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_stb inst%0d: rise=%b fall=%b, required 0/0", i, o_rise[i], o_fall[i]);
            end
`endif
        end
        rst_n = 1'b1;
    endtask

    task automatic test_offset_period();
        int   rises[$];
        int   falls[$];
        int   run_edge;
        logic prev;
        reset_all();
        tb_en    = 6'b000001;
        prev     = 1'b0;
        run_edge = -1;
        for (int e = 1; e <= 14; e++) begin
            @(negedge sysclk);
            n_tests++;
            if (o_clk[0] !== mclk(0, m_n[0]) || o_run[0] !== mrun(0, m_n[0])) begin
                n_fail++;
                $display("FAIL period_model edge%0d: clk=%b run=%b, required %b/%b", e, o_clk[0], o_run[0],
                         mclk(0, m_n[0]), mrun(0, m_n[0]));
            end
            if (o_clk[0] === 1'b1 && prev === 1'b0) rises.push_back(e);
            if (o_clk[0] === 1'b0 && prev === 1'b1) falls.push_back(e);
            if (o_run[0] === 1'b1 && run_edge < 0) run_edge = e;
            prev = o_clk[0];
        end
        n_tests++;
        if (rises.size() < 2 || falls.size() < 1) begin
            n_fail++;
            $display("FAIL period_edges: saw %0d rises %0d falls, required >=2 and >=1", rises.size(), falls.size());
        end else begin
            n_tests++;
            if (rises[0] != 3 || falls[0] != 6 || rises[1] != 9) begin
                n_fail++;
                $display("FAIL period_times: rise %0d fall %0d rise %0d, required 3 6 9", rises[0], falls[0], rises[1]);
            end
        end
        n_tests++;
        if (run_edge != 3) begin
            n_fail++;
            $display("FAIL running_edge: got edge %0d, required 3", run_edge);
        end
    endtask

    task automatic test_div2();
        reset_all();
        tb_en = 6'b000010;
        for (int e = 1; e <= 10; e++) begin
            @(negedge sysclk);
            n_tests++;
            if (o_clk[1] !== 1'(e % 2) || o_run[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL div2 edge%0d: clk=%b run=%b, required %0d/1", e, o_clk[1], o_run[1], e % 2);
            end
        end
    endtask

    task automatic test_pause();
        int   rise_t;
        int   fall_t;
        logic prev;
        reset_all();
        tb_en  = 6'b000100;
        prev   = 1'b0;
        rise_t = -1;
        fall_t = -1;
        for (int e = 1; e <= 16; e++) begin
            @(negedge sysclk);
            if (o_clk[2] === 1'b1 && prev === 1'b0 && rise_t < 0) rise_t = e;
            if (o_clk[2] === 1'b0 && prev === 1'b1 && fall_t < 0) fall_t = e;
            prev = o_clk[2];
            if (e >= 4 && e <= 8) begin
                n_tests++;
                if (o_clk[2] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pause_hold edge%0d: clk=%b, required 1", e, o_clk[2]);
                end
`ifdef SYS_CLOCK_GEN_STROBE_EN
                n_tests++;
                if (o_rise[2] !== 1'b0 || o_fall[2] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pause_stb edge%0d: rise=%b fall=%b, required 0/0", e, o_rise[2], o_fall[2]);
                end
`endif
            end
            // Edges 4..8 run with en low: a 5-tick pause in the high phase.
            tb_en[2] = !(e >= 3 && e < 8);
        end
        n_tests++;
        if (rise_t != 2 || fall_t - rise_t != 9) begin
            n_fail++;
            $display("FAIL pause_stretch: rise edge %0d high for %0d ticks, required edge 2 and 9 ticks",
                     rise_t, fall_t - rise_t);
        end
    endtask

    task automatic test_random_en();
        reset_all();
        for (int c = 0; c < 400; c++) begin
            tb_en[3:0] = 4'($urandom);
            tb_en[3:0] = tb_en[3:0] | 4'($urandom);
            @(negedge sysclk);
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (o_clk[i] !== mclk(i, m_n[i]) || o_run[i] !== mrun(i, m_n[i])) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d: clk=%b run=%b, required %b/%b", i, c, o_clk[i], o_run[i],
                             mclk(i, m_n[i]), mrun(i, m_n[i]));
                end
`ifdef SYS_CLOCK_GEN_STROBE_EN
                n_tests++;
                if (o_rise[i] !== mrise(i) || o_fall[i] !== mfall(i)) begin
                    n_fail++;
                    $display("FAIL random_stb inst%0d cyc%0d: rise=%b fall=%b, required %b/%b", i, c,
                             o_rise[i], o_fall[i], mrise(i), mfall(i));
                end
`endif
            end
        end
    endtask

    task automatic test_async_reset();
        int first_rise;
        reset_all();
        tb_en = 6'b000101;
        repeat (10) @(posedge sysclk);
        #2;
        n_tests++;
        if (o_clk[0] !== 1'b1 || o_clk[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: clk0=%b clk2=%b, required 1/1", o_clk[0], o_clk[2]);
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (o_clk[i] !== 1'b0 || o_run[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset inst%0d: clk=%b run=%b, required 0/0", i, o_clk[i], o_run[i]);
            end
`ifdef SYS_CLOCK_GEN_STROBE_EN
            n_tests++;
            if (o_rise[i] !== 1'b0 || o_fall[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset_stb inst%0d: rise=%b fall=%b, required 0/0", i, o_rise[i], o_fall[i]);
            end
`endif
        end
        @(negedge sysclk);
        rst_n      = 1'b1;
        first_rise = -1;
        for (int e = 1; e <= 6; e++) begin
            @(negedge sysclk);
            if (o_clk[0] === 1'b1 && first_rise < 0) first_rise = e;
        end
        n_tests++;
        if (first_rise != 3) begin
            n_fail++;
            $display("FAIL restart_rise: got edge %0d, required 3", first_rise);
        end
    endtask

    task automatic test_strobes();
        reset_all();
        tb_en = 6'b001000;
        for (int e = 1; e <= 14; e++) begin
            @(negedge sysclk);
            n_tests++;
            if (o_clk[3] !== 1'(e >= 4 && ((e - 4) % 4) < 2)) begin
                n_fail++;
                $display("FAIL strobe_clk edge%0d: clk=%b, required %b", e, o_clk[3], e >= 4 && ((e - 4) % 4) < 2);
            end
`ifdef SYS_CLOCK_GEN_STROBE_EN
            n_tests++;
            if (o_rise[3] !== 1'(e >= 4 && (e - 4) % 4 == 0) || o_fall[3] !== 1'(e >= 6 && (e - 6) % 4 == 0)) begin
                n_fail++;
                $display("FAIL strobe edge%0d: rise=%b fall=%b, required %b/%b", e, o_rise[3], o_fall[3],
                         e >= 4 && (e - 4) % 4 == 0, e >= 6 && (e - 6) % 4 == 0);
            end
`endif
        end
    endtask

    task automatic test_two_instances();
        int   re[$];
        int   rf[$];
        logic p4;
        logic p5;
        reset_all();
        tb_en = 6'b110000;
        p4    = 1'b0;
        p5    = 1'b0;
        for (int e = 1; e <= 14000; e++) begin
            @(negedge sysclk);
            if (o_clk[4] === 1'b1 && p4 === 1'b0) re.push_back(e);
            if (o_clk[5] === 1'b1 && p5 === 1'b0) rf.push_back(e);
            p4 = o_clk[4];
            p5 = o_clk[5];
            if (e % 97 == 0) begin
                n_tests++;
                if (o_clk[4] !== mclk(4, m_n[4]) || o_clk[5] !== mclk(5, m_n[5])) begin
                    n_fail++;
                    $display("FAIL pair_model edge%0d: clk4=%b clk5=%b, required %b/%b", e, o_clk[4], o_clk[5],
                             mclk(4, m_n[4]), mclk(5, m_n[5]));
                end
            end
        end
        n_tests++;
        if (re.size() < 2 || rf.size() < 2) begin
            n_fail++;
            $display("FAIL pair_rises: saw %0d and %0d rises, required >=2 each", re.size(), rf.size());
        end else begin
            n_tests++;
            if (re[0] != 1235 || re[1] - re[0] != 10000 || rf[1] - rf[0] != 10000) begin
                n_fail++;
                $display("FAIL pair_period: first %0d periods %0d/%0d, required 1235 and 10000/10000",
                         re[0], re[1] - re[0], rf[1] - rf[0]);
            end
            n_tests++;
            if (rf[0] - re[0] != 2484 || rf[1] - re[1] != 2484) begin
                n_fail++;
                $display("FAIL pair_sep: %0d/%0d, required 2484/2484", rf[0] - re[0], rf[1] - re[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_offset_period();
        test_div2();
        test_pause();
        test_random_en();
        test_async_reset();
        test_strobes();
        test_two_instances();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
